// File: rtl/module_debouncer.sv
// -----------------------------------------------------------------------------
// module_debouncer
//
// Input-conditioning stage for one raw, bouncing, active-low push-button.
// Produces a clean debounced level plus single-cycle press/release pulses.
// Everything runs on posedge clk with a synchronous, active-high reset.
//
// Optional feature (compile-time macro): DEBOUNCE_LONG_PRESS_EN
//   Defined   : long_press_o pulses once after the button has been held
//               debounced-pressed for LONG_CYCLES cycles; it rearms only
//               after an accepted release.
//   Undefined : no long-press logic is built; long_press_o is constant 0.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept a change (>= 2)
//   LONG_CYCLES      held-pressed cycles before long_press_o fires (>= 2)
//
// Ports:
//   clk              system clock
//   rst              synchronous reset, active-high
//   btn_ni           raw button, asynchronous, active-low (0 = pressed)
//   btn_level_o      debounced level, 1 = pressed (registered)
//   press_pulse_o    one-cycle pulse on an accepted press (registered)
//   release_pulse_o  one-cycle pulse on an accepted release (registered)
//   long_press_o     one-cycle pulse on a long press (registered, or tied 0)
// -----------------------------------------------------------------------------
module module_debouncer #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_ni,
  output logic btn_level_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_press_o
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_CHK,
    ST_PRESSED,
    ST_RELEASE_CHK
  } state_e;

  logic             sync1_q, sync2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_level_q, btn_level_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             pressed_s;

  // Synchronized sample, inverted so 1 means pressed.
  assign pressed_s = ~sync2_q;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;

    unique case (state_q)
      ST_RELEASED: begin
        if (pressed_s) begin
          state_d = ST_PRESS_CHK;
          cnt_d   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!pressed_s) begin
          state_d = ST_RELEASED;     // bounce rejected
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d       = ST_PRESSED;
          cnt_d         = '0;
          press_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!pressed_s) begin
          state_d = ST_RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_CHK: begin
        if (pressed_s) begin
          state_d = ST_PRESSED;      // release glitch rejected
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d         = ST_RELEASED;
          cnt_d           = '0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase

    // Level is registered from the next state so it rises together with the
    // press pulse and falls together with the release pulse.
    btn_level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_CHK);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      sync1_q         <= 1'b1;       // released
      sync2_q         <= 1'b1;
      state_q         <= ST_RELEASED;
      cnt_q           <= '0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      sync1_q         <= btn_ni;
      sync2_q         <= sync1_q;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign btn_level_o     = btn_level_q;
  assign press_pulse_o   = press_pulse_q;
  assign release_pulse_o = release_pulse_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
  // ---------------------------------------------------------------------------
  // Long-press detection
  // ---------------------------------------------------------------------------
  localparam int LONG_W = ($clog2(LONG_CYCLES) > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              fired_q, fired_d;     // long pulse already issued this press
  logic              long_press_q, long_press_d;

  always_comb begin
    long_cnt_d   = long_cnt_q;
    fired_d      = fired_q;
    long_press_d = 1'b0;

    if (press_pulse_d) begin
      long_cnt_d = '0;                     // entering PRESSED from PRESS_CHK
    end else if ((state_q == ST_PRESSED) || (state_q == ST_RELEASE_CHK)) begin
      if (long_cnt_q == LONG_LAST) begin
        // Saturated: fire once, then hold until an accepted release rearms.
        if (!fired_q) begin
          long_press_d = 1'b1;
          fired_d      = 1'b1;
        end
      end else begin
        long_cnt_d = long_cnt_q + 1'b1;
      end
    end

    if (release_pulse_d) begin
      fired_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      long_cnt_q   <= '0;
      fired_q      <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      long_cnt_q   <= long_cnt_d;
      fired_q      <= fired_d;
      long_press_q <= long_press_d;
    end
  end

  assign long_press_o = long_press_q;
`else
  assign long_press_o = 1'b0;
`endif

endmodule

// File: tb/tb_module_debouncer.sv
// -----------------------------------------------------------------------------
// tb_module_debouncer
//
// Directed bench for module_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
// Edges are counted from the first posedge that samples a new btn_ni value;
// outputs are sampled 1 time unit after each posedge.
// -----------------------------------------------------------------------------
module tb_module_debouncer;

  localparam int DB   = 4;
  localparam int LONG = 10;
  localparam int LAT  = DB + 3;            // edges from input change to pulse

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic btn_ni;
  logic btn_level_o;
  logic press_pulse_o;
  logic release_pulse_o;
  logic long_press_o;

  int checks = 0;
  int errors = 0;

  module_debouncer #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_ni         (btn_ni),
    .btn_level_o    (btn_level_o),
    .press_pulse_o  (press_pulse_o),
    .release_pulse_o(release_pulse_o),
    .long_press_o   (long_press_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic lvl, input logic prs,
                           input logic rel, input logic lng);
    check({tag, " level"},   btn_level_o,     lvl);
    check({tag, " press"},   press_pulse_o,   prs);
    check({tag, " release"}, release_pulse_o, rel);
    check({tag, " long"},    long_press_o,    lng);
  endtask

  // btn_ni must already be low; press accepted after edge LAT, then one more edge.
  task automatic expect_press(input string tag);
    for (int i = 1; i <= LAT; i++) begin
      tick();
      check_all($sformatf("%s e%0d", tag, i), (i == LAT), (i == LAT), 1'b0, 1'b0);
    end
    tick();
    check_all({tag, " after"}, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Drives btn_ni high; release accepted after edge LAT, then one more edge.
  task automatic expect_release(input string tag);
    btn_ni = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      check_all($sformatf("%s e%0d", tag, i), (i != LAT), 1'b0, (i == LAT), 1'b0);
    end
    tick();
    check_all({tag, " after"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst    = 1'b1;
    btn_ni = 1'b0;

    // Reset held 3 cycles with the button pressed: outputs stay 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("reset c%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    expect_press("post_reset_press");

    // Keep holding, with a 2-cycle release glitch; long counter keeps running.
    // press pulse was at pulse-edge P; "after" was P+1, so k counts from P+1.
    for (int k = 1; k <= 30; k++) begin
      if (k == 2) btn_ni = 1'b1;
      if (k == 4) btn_ni = 1'b0;
      if (k > 1) tick();
      check_all($sformatf("hold_glitch k%0d", k), 1'b1, 1'b0, 1'b0,
                LONG_EN && (k == LONG));
    end

    expect_release("release1");

    // Second press after a release: long pulse rearmed.
    btn_ni = 1'b0;
    expect_press("press2");
    for (int k = 2; k <= 12; k++) begin
      tick();
      check_all($sformatf("press2_hold k%0d", k), 1'b1, 1'b0, 1'b0,
                LONG_EN && (k == LONG));
    end
    expect_release("release2");

    // Bounce: 0,1,0,1 every 2 cycles then held high -> never accepted.
    for (int k = 0; k < 18; k++) begin
      if (k < 8) btn_ni = ((k / 2) % 2 == 1);
      else       btn_ni = 1'b1;
      tick();
      check_all($sformatf("bounce k%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset mid-debounce: reset applied at edge 5 of a press.
    btn_ni = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check_all($sformatf("mid_deb e%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    tick();
    check_all("mid_deb reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    expect_press("after_mid_reset");
    expect_release("release3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
